// File: rtl/rggen_host_arbiter_if.sv
// Bundle of per-host rggen request/response lanes plus the single shared register-side port.
// "master" is the environment view (hosts and register block); "slave" is the arbiter view.
interface rggen_host_arbiter_if #(
    parameter int unsigned HOSTS         = 2,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic [HOSTS-1:0]               valid;
    logic [2*HOSTS-1:0]             access;
    logic [ADDRESS_WIDTH*HOSTS-1:0] address;
    logic [BUS_WIDTH*HOSTS-1:0]     write_data;
    logic [BUS_WIDTH*HOSTS-1:0]     strobe;
    logic [HOSTS-1:0]               ready;
    logic [2*HOSTS-1:0]             status;
    logic [BUS_WIDTH*HOSTS-1:0]     read_data;

    logic                           reg_valid;
    logic [1:0]                     reg_access;
    logic [ADDRESS_WIDTH-1:0]       reg_address;
    logic [BUS_WIDTH-1:0]           reg_write_data;
    logic [BUS_WIDTH-1:0]           reg_strobe;
    logic                           reg_ready;
    logic [1:0]                     reg_status;
    logic [BUS_WIDTH-1:0]           reg_read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        output reg_ready, reg_status, reg_read_data,
        input  ready, status, read_data,
        input  reg_valid, reg_access, reg_address, reg_write_data, reg_strobe
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        input  reg_ready, reg_status, reg_read_data,
        output ready, status, read_data,
        output reg_valid, reg_access, reg_address, reg_write_data, reg_strobe
    );
endinterface

// File: rtl/rggen_host_arbiter.sv
// Round-robin sharing of one rggen register-bus port between HOSTS masters; the grant is held
// until the register side answers or the optional watchdog forces a slave error.
module rggen_host_arbiter #(
    parameter int unsigned HOSTS         = 2,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32,
    parameter int unsigned TIMEOUT       = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rggen_host_arbiter_if.slave  bus_if,
    output logic [HOSTS-1:0]     o_grant
);
    localparam int unsigned       IDX_W              = (HOSTS > 1) ? $clog2(HOSTS) : 1;
    localparam int unsigned       WD_W               = 16;
    localparam logic [1:0]        STATUS_SLAVE_ERROR = 2'b10;
    localparam bit                WD_EN              = (TIMEOUT != 0);
    localparam logic [WD_W-1:0]   WD_LAST            = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [IDX_W-1:0]           r_owner;
    logic [IDX_W-1:0]           r_ptr;
    logic [HOSTS-1:0]           r_grant;
    logic [1:0]                 r_access;
    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic [BUS_WIDTH-1:0]       r_write_data;
    logic [BUS_WIDTH-1:0]       r_strobe;
    logic [WD_W-1:0]            r_watchdog;

    logic                       w_found;
    logic [IDX_W-1:0]           w_sel;
    logic                       w_timeout;
    logic                       w_done;
    logic [HOSTS-1:0]           w_ready;
    logic [2*HOSTS-1:0]         w_status;
    logic [BUS_WIDTH*HOSTS-1:0] w_read_data;

    // First requester found scanning upward from the host after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned k = 1; k <= HOSTS; k++) begin
            if (!w_found && bus_if.valid[IDX_W'((32'(r_ptr) + k) % HOSTS)]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'((32'(r_ptr) + k) % HOSTS);
            end
        end
    end

    // Completion steers the register response (or a forced error) to the owner only.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        w_ready      = '0;
        w_status     = '0;
        w_read_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_timeout = WD_EN && (r_watchdog == WD_LAST);
                w_done    = bus_if.reg_ready || w_timeout;
                if (w_done) begin
                    w_next_state     = ST_IDLE;
                    w_ready[r_owner] = 1'b1;
                    if (bus_if.reg_ready) begin
                        w_status[2*r_owner +: 2]                    = bus_if.reg_status;
                        w_read_data[BUS_WIDTH*r_owner +: BUS_WIDTH] = bus_if.reg_read_data;
                    end else begin
                        w_status[2*r_owner +: 2] = STATUS_SLAVE_ERROR;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_ptr        <= IDX_W'(HOSTS - 1);
            r_grant      <= '0;
            r_access     <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
            r_watchdog   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner      <= w_sel;
                        r_grant      <= HOSTS'(1) << w_sel;
                        r_access     <= bus_if.access[2*w_sel +: 2];
                        r_address    <= bus_if.address[ADDRESS_WIDTH*w_sel +: ADDRESS_WIDTH];
                        r_write_data <= bus_if.write_data[BUS_WIDTH*w_sel +: BUS_WIDTH];
                        r_strobe     <= bus_if.strobe[BUS_WIDTH*w_sel +: BUS_WIDTH];
                        r_watchdog   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_ptr   <= r_owner;
                        r_grant <= '0;
                    end else begin
                        r_watchdog <= r_watchdog + WD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_if.ready          = w_ready;
    assign bus_if.status         = w_status;
    assign bus_if.read_data      = w_read_data;
    assign bus_if.reg_valid      = (r_state == ST_ACCESS);
    assign bus_if.reg_access     = r_access;
    assign bus_if.reg_address    = r_address;
    assign bus_if.reg_write_data = r_write_data;
    assign bus_if.reg_strobe     = r_strobe;
    assign o_grant               = r_grant;

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Directed bench for rggen_host_arbiter: a per-cycle behavioural arbiter model plus
// hand-computed expectations for each scenario.
module tb_rggen_host_arbiter;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 8;
    localparam int unsigned BW = 32;
    localparam int unsigned TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [H-1:0] grant;
    int           n_checks = 0;
    int           n_fail   = 0;

    // Model: owner (-1 when free), cycles spent by the owner, last owner, command taken at grant.
    int           m_owner = -1;
    int           m_age   = 0;
    int           m_ptr   = H - 1;
    logic [1:0]   m_acc   = '0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_wd   = '0;
    logic [BW-1:0] m_st   = '0;

    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    int t_order[$];
    int t_when[$];

    rggen_host_arbiter_if #(.HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

    rggen_host_arbiter #(
        .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT(TO)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus_if  (bus),
        .o_grant (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [H-1:0] g);
        for (int i = 0; i < H; i++) begin
            if (g[i +: 1] == 1'b1) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic          done;
        logic [1:0]    rsp_st;
        logic [BW-1:0] rsp_rd;
        logic [H-1:0]  exp_g;
        bit            found;
        if (rst) begin
            m_owner = -1;
            m_age   = 0;
            m_ptr   = H - 1;
        end
        done   = !rst && (m_owner >= 0) && (bus.reg_ready || (TO != 0 && m_age == TO - 1));
        rsp_st = bus.reg_ready ? bus.reg_status : 2'b10;
        rsp_rd = bus.reg_ready ? bus.reg_read_data : '0;
        exp_g  = (m_owner >= 0) ? (H'(1) << m_owner) : '0;
        check("grant", 64'(grant), 64'(exp_g));
        check("reg_valid", 64'(bus.reg_valid), 64'(m_owner >= 0));
        if (m_owner >= 0) begin
            check("reg_access", 64'(bus.reg_access), 64'(m_acc));
            check("reg_address", 64'(bus.reg_address), 64'(m_addr));
            check("reg_write_data", 64'(bus.reg_write_data), 64'(m_wd));
            check("reg_strobe", 64'(bus.reg_strobe), 64'(m_st));
        end
        for (int h = 0; h < H; h++) begin
            bit mine;
            mine = done && (h == m_owner);
            check("ready", 64'(bus.ready[h +: 1]), 64'(mine));
            check("status", 64'(bus.status[2*h +: 2]), mine ? 64'(rsp_st) : 64'd0);
            check("read_data", 64'(bus.read_data[BW*h +: BW]), mine ? 64'(rsp_rd) : 64'd0);
        end
        if (rst) return;
        if (done) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else if (m_owner >= 0) begin
            m_age++;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= H; k++) begin
                int hh;
                hh = (m_ptr + k) % H;
                if (!found && bus.valid[hh +: 1] == 1'b1) begin
                    found   = 1'b1;
                    m_owner = hh;
                    m_age   = 0;
                    m_acc   = bus.access[2*hh +: 2];
                    m_addr  = bus.address[AW*hh +: AW];
                    m_wd    = bus.write_data[BW*hh +: BW];
                    m_st    = bus.strobe[BW*hh +: BW];
                end
            end
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_host(input int h, input logic v, input logic [1:0] acc,
                            input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [BW-1:0] s);
        bus.valid[h +: 1]           = v;
        bus.access[2*h +: 2]        = acc;
        bus.address[AW*h +: AW]     = a;
        bus.write_data[BW*h +: BW]  = d;
        bus.strobe[BW*h +: BW]      = s;
    endtask

    task automatic set_reg(input logic r, input logic [1:0] st, input logic [BW-1:0] d);
        bus.reg_ready     = r;
        bus.reg_status    = st;
        bus.reg_read_data = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid = '0; bus.access = '0; bus.address = '0;
        bus.write_data = '0; bus.strobe = '0;
        set_reg(1'b0, 2'b00, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hi0, rdy_c, g2_c;
        logic [1:0]    rs;
        logic [BW-1:0] rd;

        // 1: single write from host 0, register answers on the second ACCESS cycle
        do_reset();
        set_host(0, 1'b1, 2'b10, 8'h04, 32'hDEADBEEF, '1);
        @(negedge clk);
        check("t1_idle_reg_valid", 64'(bus.reg_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t1_reg_valid", 64'(bus.reg_valid), 64'd1);
        check("t1_grant", 64'(grant), 64'h1);
        check("t1_address", 64'(bus.reg_address), 64'h04);
        check("t1_write_data", 64'(bus.reg_write_data), 64'hDEADBEEF);
        check("t1_strobe", 64'(bus.reg_strobe), 64'hFFFFFFFF);
        check("t1_access", 64'(bus.reg_access), 64'h2);
        tick();
        set_reg(1'b1, 2'b00, 32'h0);
        @(negedge clk);
        check("t1_ready", 64'(bus.ready), 64'h1);
        check("t1_status", 64'(bus.status), 64'h0);
        tick();
        set_reg(1'b0, 2'b00, '0);
        set_host(0, 1'b0, 2'b10, 8'h04, 32'hDEADBEEF, '1);
        @(negedge clk);
        check("t1_grant_clear", 64'(grant), 64'h0);
        check("t1_reg_valid_clear", 64'(bus.reg_valid), 64'd0);

        // 2: three hosts requesting continuously, register always ready
        do_reset();
        for (int h = 0; h < H; h++) set_host(h, 1'b1, 2'b00, AW'(16 + h), '0, '1);
        set_reg(1'b1, 2'b01, 32'hA5A50000);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.reg_valid) begin
                t_order.push_back(onehot_idx(grant));
                t_when.push_back(c);
            end
            tick();
        end
        check("t2_grant_count", 64'(t_order.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("t2_order", 64'((i < t_order.size()) ? t_order[i] : -1), 64'(exp_order[i]));
        end
        for (int i = 1; i < 6; i++) begin
            check("t2_spacing", 64'((i < t_when.size()) ? t_when[i] - t_when[i-1] : -1), 64'd2);
        end

        // 3: register never ready; watchdog ends host 0 after 4 cycles, host 2 follows
        do_reset();
        set_host(0, 1'b1, 2'b00, 8'h20, '0, '1);
        set_host(2, 1'b1, 2'b00, 8'h30, '0, '1);
        hi0 = 0; rdy_c = -1; g2_c = -1; rs = 2'b11; rd = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.reg_valid && grant == 3'b001) hi0++;
            if (bus.ready[0]) begin
                rdy_c = c;
                rs    = bus.status[1:0];
                rd    = bus.read_data[BW-1:0];
            end
            if (g2_c < 0 && grant == 3'b100) g2_c = c;
            tick();
            if (rdy_c == c) set_host(0, 1'b0, 2'b00, 8'h20, '0, '1);
        end
        check("t3_valid_cycles", 64'(hi0), 64'd4);
        check("t3_ready_cycle", 64'(rdy_c), 64'd4);
        check("t3_status", 64'(rs), 64'h2);
        check("t3_read_data", 64'(rd), 64'h0);
        check("t3_next_grant_cycle", 64'(g2_c), 64'd6);

        // 4: ready on the 4th ACCESS cycle wins over the watchdog
        do_reset();
        set_host(1, 1'b1, 2'b00, 8'h40, '0, '1);
        repeat (4) tick();
        set_reg(1'b1, 2'b00, 32'h1234);
        @(negedge clk);
        check("t4_ready", 64'(bus.ready), 64'h2);
        check("t4_status", 64'(bus.status[3:2]), 64'h0);
        check("t4_read_data", 64'(bus.read_data[2*BW-1:BW]), 64'h1234);
        tick();
        set_reg(1'b0, 2'b00, '0);
        set_host(1, 1'b0, 2'b00, 8'h40, '0, '1);
        @(negedge clk);
        check("t4_grant_clear", 64'(grant), 64'h0);

        // 5: host 1 changes its address and withdraws mid-access
        do_reset();
        set_host(1, 1'b1, 2'b10, 8'h08, 32'h5555AAAA, '1);
        tick();
        set_host(1, 1'b0, 2'b10, 8'h10, 32'h0, '1);
        @(negedge clk);
        check("t5_address", 64'(bus.reg_address), 64'h08);
        check("t5_write_data", 64'(bus.reg_write_data), 64'h5555AAAA);
        tick();
        @(negedge clk);
        check("t5_address_hold", 64'(bus.reg_address), 64'h08);
        check("t5_valid_hold", 64'(bus.reg_valid), 64'd1);
        tick();
        set_reg(1'b1, 2'b00, 32'h0);
        @(negedge clk);
        check("t5_ready", 64'(bus.ready), 64'h2);
        check("t5_address_end", 64'(bus.reg_address), 64'h08);
        tick();
        set_reg(1'b0, 2'b00, '0);
        @(negedge clk);
        check("t5_no_regrant", 64'(grant), 64'h0);

        // 6: reset in the middle of an access, then simultaneous 0/1 request
        do_reset();
        set_host(0, 1'b1, 2'b00, 8'h50, '0, '1);
        tick();
        #1;
        rst = 1'b1;
        set_reg(1'b1, 2'b00, 32'hFFFF);
        #1;
        check("t6_reg_valid_async", 64'(bus.reg_valid), 64'd0);
        check("t6_grant_async", 64'(grant), 64'h0);
        check("t6_no_ready", 64'(bus.ready), 64'h0);
        @(posedge clk);
        #1;
        set_reg(1'b0, 2'b00, '0);
        rst = 1'b0;
        set_host(0, 1'b1, 2'b00, 8'h60, '0, '1);
        set_host(1, 1'b1, 2'b00, 8'h61, '0, '1);
        tick();
        @(negedge clk);
        check("t6_host0_wins", 64'(grant), 64'h1);
        check("t6_address", 64'(bus.reg_address), 64'h60);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
